// File: rtl/clarke_tdm_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : clarke_tdm_scheduler
// Purpose  : Shares one fixed-latency, non-stallable inverse Clarke core
//            between NUM_CH requesters. Round-robin grant on valid/ready
//            request ports, a channel-tag pipe that follows each sample
//            through the core, and a credit-protected show-ahead result
//            FIFO drained on a valid/ready port tagged with the channel id.
// Ports    : clk_i, rst_i (async, active-high), en_i, busy_o
//            req_valid_i/req_al_i/req_be_i/req_ready_o : requester side
//            core_al_o/core_be_o -> core, core_a_i/core_b_i <- core
//            res_valid_o/res_ready_i/res_ch_o/res_a_o/res_b_o : result side
// Options  : CLARKE_SCHED_STATS_EN adds stat_issue_o / stat_stall_o
//            (16-bit saturating issue and credit-stall counters).
// Revision : 1.0 - initial release
// ============================================================================
module clarke_tdm_scheduler #(
  parameter int DATA_WIDTH = 10,
  parameter int NUM_CH     = 4,
  parameter int CORE_LAT   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         en_i,
  output logic                                         busy_o,
  input  logic [NUM_CH-1:0]                            req_valid_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]                 req_al_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]                 req_be_i,
  output logic [NUM_CH-1:0]                            req_ready_o,
  output logic [DATA_WIDTH-1:0]                        core_al_o,
  output logic [DATA_WIDTH-1:0]                        core_be_o,
  input  logic [DATA_WIDTH-1:0]                        core_a_i,
  input  logic [DATA_WIDTH-1:0]                        core_b_i,
  output logic                                         res_valid_o,
  input  logic                                         res_ready_i,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] res_ch_o,
  output logic [DATA_WIDTH-1:0]                        res_a_o,
  output logic [DATA_WIDTH-1:0]                        res_b_o
`ifdef CLARKE_SCHED_STATS_EN
  ,
  output logic [15:0]                                  stat_issue_o,
  output logic [15:0]                                  stat_stall_o
`endif
);

  localparam int c_CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Elaboration-time parameter checks
  if (FIFO_DEPTH < CORE_LAT + 1) begin : g_bad_depth
    $error("clarke_tdm_scheduler: FIFO_DEPTH must be >= CORE_LAT+1");
  end
  if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
    $error("clarke_tdm_scheduler: NUM_CH must be in 2..16");
  end
  if (CORE_LAT < 1 || CORE_LAT > 8) begin : g_bad_lat
    $error("clarke_tdm_scheduler: CORE_LAT must be in 1..8");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [c_CH_W-1:0]     r_rr_ptr;
  logic [c_CNT_W-1:0]    r_inflight;
  logic [c_CNT_W-1:0]    r_count;
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;

  logic [CORE_LAT-1:0]   r_tag_v;
  logic [c_CH_W-1:0]     r_tag_ch [CORE_LAT];

  logic [c_CH_W-1:0]     r_fifo_ch [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_a  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_b  [FIFO_DEPTH];

  logic [DATA_WIDTH-1:0] w_al [NUM_CH];
  logic [DATA_WIDTH-1:0] w_be [NUM_CH];

  logic [c_CNT_W:0]      w_credit_sum;
  logic                  w_credit_ok;
  logic                  w_issue_en;
  logic                  w_gnt_found;
  logic [c_CH_W-1:0]     w_gnt_idx;
  logic [c_CH_W-1:0]     w_cand;
  logic                  w_xfer;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;

  // Unpack the per-channel sample buses
  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign w_al[k] = req_al_i[k*DATA_WIDTH +: DATA_WIDTH];
    assign w_be[k] = req_be_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
    if (p == c_PTR_W'(FIFO_DEPTH - 1)) begin
      f_ptr_inc = '0;
    end else begin
      f_ptr_inc = p + 1'b1;
    end
  endfunction

  // Credit: every sample in the core already owns a FIFO slot. Same-cycle
  // push/pop are ignored, so this can only under-issue, never overflow.
  assign w_credit_sum = {1'b0, r_inflight} + {1'b0, r_count};
  assign w_credit_ok  = (w_credit_sum < (c_CNT_W + 1)'(FIFO_DEPTH));
  assign w_issue_en   = (r_state == ST_RUN) && w_credit_ok;

  // Round-robin search starting one past the last granted channel
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_cand = c_CH_W'((int'(r_rr_ptr) + i) % NUM_CH);
      if (!w_gnt_found && req_valid_i[w_cand]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_cand;
      end
    end
  end

  assign w_xfer = w_issue_en && w_gnt_found;

  always_comb begin
    req_ready_o = '0;
    if (w_xfer) begin
      req_ready_o[w_gnt_idx] = 1'b1;
    end
  end

  assign core_al_o = w_xfer ? w_al[w_gnt_idx] : '0;
  assign core_be_o = w_xfer ? w_be[w_gnt_idx] : '0;

  // FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (en_i) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!en_i) begin
          if (r_inflight != '0 || !w_empty) w_state_nxt = ST_DRAIN;
          else                              w_state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (en_i)                               w_state_nxt = ST_RUN;
        else if (r_inflight == '0 && w_empty)   w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy_o = (r_state != ST_IDLE);

  // Round-robin pointer moves only on a completed transfer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr <= c_CH_W'(NUM_CH - 1);
    end else if (w_xfer) begin
      r_rr_ptr <= w_gnt_idx;
    end
  end

  // Tag pipe: stage 0 is written at the capture edge; the last stage is
  // valid in the same cycle the core presents that sample's result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tag_v <= '0;
      for (int i = 0; i < CORE_LAT; i++) begin
        r_tag_ch[i] <= '0;
      end
    end else begin
      r_tag_v[0]  <= w_xfer;
      r_tag_ch[0] <= w_gnt_idx;
      for (int i = 1; i < CORE_LAT; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_ch[i] <= r_tag_ch[i-1];
      end
    end
  end

  assign w_push  = r_tag_v[CORE_LAT-1];
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && res_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_inflight <= '0;
    end else begin
      case ({w_xfer, w_push})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Result FIFO control
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage needs no reset: outputs are masked while empty
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_ch[r_wr_ptr] <= r_tag_ch[CORE_LAT-1];
      r_fifo_a[r_wr_ptr]  <= core_a_i;
      r_fifo_b[r_wr_ptr]  <= core_b_i;
    end
  end

  assign res_valid_o = !w_empty;
  assign res_ch_o    = w_empty ? '0 : r_fifo_ch[r_rd_ptr];
  assign res_a_o     = w_empty ? '0 : r_fifo_a[r_rd_ptr];
  assign res_b_o     = w_empty ? '0 : r_fifo_b[r_rd_ptr];

  a_no_push_when_full : assert property (
    @(posedge clk_i) disable iff (rst_i)
      !(w_push && (r_count == c_CNT_W'(FIFO_DEPTH)))
  );

`ifdef CLARKE_SCHED_STATS_EN
  logic w_stall;
  assign w_stall = (r_state == ST_RUN) && (|req_valid_i) && !w_credit_ok;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_issue_o <= '0;
      stat_stall_o <= '0;
    end else begin
      if (w_xfer && stat_issue_o != 16'hFFFF)  stat_issue_o <= stat_issue_o + 1'b1;
      if (w_stall && stat_stall_o != 16'hFFFF) stat_stall_o <= stat_stall_o + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/clarke_tdm_scheduler.md
Name: clarke_tdm_scheduler

Overview:
- Time-multiplexes one shared inverse Clarke core (fixed latency, non-stallable) between NUM_CH requesters.
- Round-robin arbitration on valid/ready request ports; the granted channel's alpha/beta is driven to the core.
- A channel tag tracks each sample through the core latency. Results land in a credit-protected result FIFO and leave on a valid/ready port tagged with channel id.
- Sits between per-phase-group current/voltage producers and PWM/SVM consumers.

Parameters:
DATA_WIDTH, 10, signed sample width of alpha/beta/a/b
NUM_CH, 4, number of requesters (2..16)
CORE_LAT, 1, core latency in clock edges from input capture to valid output (1..8)
FIFO_DEPTH, 4, result FIFO entries; must be >= CORE_LAT+1 (elaboration error otherwise)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
en_i  in  1  scheduler enable
busy_o  out  1  state != IDLE
req_valid_i  in  NUM_CH  per-channel request valid
req_al_i  in  NUM_CH*DATA_WIDTH  packed alpha, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
req_be_i  in  NUM_CH*DATA_WIDTH  packed beta, same packing
req_ready_o  out  NUM_CH  one-hot grant, at most one bit set
core_al_o  out  DATA_WIDTH  alpha to core
core_be_o  out  DATA_WIDTH  beta to core
core_a_i  in  DATA_WIDTH  core phase-a result
core_b_i  in  DATA_WIDTH  core phase-b result
res_valid_o  out  1  result available
res_ready_i  in  1  consumer accepts
res_ch_o  out  max(1,$clog2(NUM_CH))  channel id of result
res_a_o  out  DATA_WIDTH  phase a
res_b_o  out  DATA_WIDTH  phase b

Behaviour:
- Clock/reset: one clock clk_i; rst_i asynchronous, active-high.
- Reset values: all outputs 0; rr pointer = NUM_CH-1, so channel 0 wins first; tag pipe cleared; FIFO empty; state IDLE. Reset mid-operation discards in-flight tags and FIFO contents.
- FSM states:
  - IDLE -> RUN when en_i=1.
  - RUN -> DRAIN when en_i=0 and (inflight!=0 or FIFO non-empty).
  - RUN -> IDLE when en_i=0 and everything is empty.
  - DRAIN -> IDLE when inflight=0 and FIFO empty.
  - DRAIN -> RUN when en_i=1.
- Issue rule: issue only in RUN when inflight + fifo_count < FIFO_DEPTH (credit check).
  - Issue-cycle FIFO pop and push are not counted; the check is conservative.
- Grant: first channel with req_valid_i set, searching from pointer+1 upward with wrap. req_ready_o is combinational from req_valid_i, state and credit.
  - Requesters must not make valid depend on ready.
  - Transfer completes at the edge where valid & ready. The pointer updates to the granted index only on a transfer.
- Core drive: core_al_o/core_be_o are a combinational mux of the granted channel's inputs in the issue cycle; 0 when there is no grant. The core captures them at the transfer edge E.
- Tag pipe: CORE_LAT stages of {valid, ch}. The stage written at E reaches the last stage in the cycle core_a_i/core_b_i are valid for that sample. The last-stage valid pushes {ch, core_a_i, core_b_i} into the FIFO at edge E+CORE_LAT.
- FIFO: show-ahead. res_valid_o = !empty; res_* reflect head. Pop on res_valid_o & res_ready_i. Push and pop in the same cycle are both honoured. The credit check guarantees push never occurs when full; a push while full is a design error, flagged with an assertion.
- Latency: transfer at edge E -> res_valid_o high after edge E+CORE_LAT when the FIFO was empty.
- Throughput: 1 sample/cycle while res_ready_i=1.
- inflight count: +1 on issue, -1 on last-stage valid, both in the same cycle net 0. Width $clog2(FIFO_DEPTH+1).

Optional Feature:
- Macro: CLARKE_SCHED_STATS_EN.
- When defined, two extra output ports are added:
  - stat_issue_o: 16 bits, saturating count of issued samples.
  - stat_stall_o: 16 bits, saturating count of cycles in RUN with any req_valid_i set but no grant because credit was exhausted.
- Both counters reset to 0 and saturate at 16'hFFFF.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Setup for all scenarios: DATA_WIDTH=10, CORE_LAT=1, FIFO_DEPTH=4, bench core model of the 1-cycle inverse Clarke.
- Single request: en_i=1, ch0 al=100 be=0 -> req_ready_o=4'b0001 in same cycle; res_valid_o after next edge with res_ch_o=0, res_a_o=100, res_b_o=-50.
- Round robin: ch0..ch3 all valid continuously, res_ready_i=1 -> grants 0,1,2,3,0 on consecutive cycles; results in the same order, one per cycle.
- Backpressure: res_ready_i=0, all channels valid -> exactly 4 issues, then req_ready_o=0; FIFO holds 4 entries. Raise res_ready_i -> issuing resumes the cycle after the first pop; no sample lost or duplicated.
- Drain: drop en_i with 2 samples in flight/FIFO -> no new grants, busy_o=1 until both results are popped, then busy_o=0 and state IDLE.
- Reset mid-operation: assert rst_i with 3 FIFO entries -> res_valid_o=0 and req_ready_o=0 immediately; after release, first grant goes to ch0.
- Stats (CLARKE_SCHED_STATS_EN): backpressure scenario held 10 stall cycles -> stat_issue_o=4, stat_stall_o=10.
